branch_predictor_btb: RTL and testbench
=======================================

# branch_predictor_btb

Parametrised branch predictor for the pipelined RAT CPU: per-entry saturating direction counters plus a tagged branch target buffer, with an optional gshare-style global history index. Sits beside the fetch stage. A lookup is a zero-latency read against the PC currently on the program ROM address line. Updates arrive from the execute stage when a branch resolves. It replaces the fixed 1-bit, untagged table with configurable depth, counter width, target storage, history and miss statistics.

## Interface
- ADDR_W, 10, program address width
- ENTRIES, 16, table depth; power of 2, >= 2; IDX_W = $clog2(ENTRIES), TAG_W = ADDR_W - IDX_W
- CNT_W, 2, direction counter width, >= 1
- GHR_W, 4, global history length; 1 <= GHR_W <= IDX_W
- GSHARE, 0, 1 = counter index is pc[IDX_W-1:0] XOR zero-extended history; 0 = pc[IDX_W-1:0] only
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- lookup_pc  in  ADDR_W  fetch PC to predict
- pred_taken  out  1  predict taken
- pred_hit  out  1  BTB tag hit for lookup_pc
- pred_target  out  ADDR_W  predicted target; 0 when pred_hit = 0
- pred_ghr  out  GHR_W  history snapshot used for this lookup; the pipeline carries it to upd_ghr
- upd_valid  in  1  resolved branch this cycle
- upd_pc  in  ADDR_W  PC of the resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual taken target
- upd_ghr  in  GHR_W  pred_ghr value that travelled with the branch
- upd_mispredict  in  1  execute detected a miss (qualified by upd_valid)
- clr  in  1  synchronous flush of all predictor state
- miss_count  out  16  saturating mispredict counter

## Operation
- Storage per BTB entry: valid, tag, target, indexed by pc[IDX_W-1:0]. PHT: ENTRIES counters of CNT_W bits, indexed by the hash.
- Counter init value is 2^(CNT_W-1)-1 (weakly not-taken). A counter predicts taken when its MSB = 1.
- pred_hit = valid[idx] & (tag[idx] == lookup_pc[ADDR_W-1:IDX_W]).
- pred_taken = pred_hit & counter MSB. On a BTB miss the prediction is always not-taken.
- pred_ghr = current GHR.
- When upd_valid = 1:
  - The PHT index is computed from upd_pc and upd_ghr, never from the live GHR.
  - The counter saturating-increments when upd_taken = 1 and saturating-decrements when upd_taken = 0. It is clamped at 0 and at 2^CNT_W-1.
  - When upd_taken = 1, the BTB entry is written: valid = 1, tag from upd_pc, target = upd_target. A different tag is overwritten.
  - When upd_taken = 0, the BTB is untouched; no allocation occurs on not-taken.
  - GHR <= {GHR[GHR_W-2:0], upd_taken}. For GHR_W = 1, GHR <= upd_taken.
  - When upd_mispredict = 1, miss_count increments and saturates at 16'hFFFF.
- clr = 1 clears every valid bit, sets all counters to the init value, and zeroes GHR and miss_count. clr has priority over a same-cycle upd_valid, which is dropped.

## Timing
- Lookup is combinational from registered state, with 0-cycle latency.
- An update is visible to a lookup on the cycle after the update edge.
- A same-cycle lookup and update to the same entry returns the pre-update state; there is no bypass.
- rst_n low asynchronously forces the same state as clr. All outputs read 0 while reset is held, except that counters hold the init value. Reset deassertion takes effect at the next clk edge.
- Reset mid-operation discards any in-flight update; no partial write is allowed.
- There is no state machine or stall. Every update is accepted, one per cycle.

## Structure
- Package bp_pkg holds:
  - function ctr_init(CNT_W);
  - functions sat_inc/sat_dec;
  - function pht_index(pc, ghr, GSHARE);
  - typedef btb_entry_t {valid, tag, target}.
- Sub-module bp_pht: the counter array with one combinational read port, one write port, the saturating update and the clr/reset init.
- The BTB array, GHR and miss_count stay in the top module.

## Test plan
- After reset, lookup_pc = 10'h05A -> pred_hit = 0, pred_taken = 0, pred_target = 0, pred_ghr = 0, miss_count = 0.
- One taken update, upd_pc = 10'h023, upd_target = 10'h140 (GSHARE = 0) -> next cycle, lookup 10'h023 gives hit = 1, target = 10'h140, taken = 1 (counter 1 -> 2).
- Three taken updates to 10'h023 (counter saturates at 3), then one not-taken -> still taken. A second not-taken -> pred_taken = 0 with pred_hit = 1.
- After allocating 10'h023, lookup 10'h033 (same index 3, different tag) -> pred_hit = 0, pred_taken = 0. A taken update to 10'h033 evicts it, and 10'h023 then misses.
- Same-cycle update to 10'h023 and lookup of 10'h023 -> lookup returns the pre-update value, and the new value the next cycle. With GSHARE = 1, updates T, N, T, T -> pred_ghr = 4'b1011.
- Sequence:
  - 70000 mispredict updates -> miss_count = 16'hFFFF.
  - Then clr with a simultaneous upd_valid -> miss_count = 0, all misses, update dropped.
  - Then rst_n pulsed low mid-cycle -> outputs cleared immediately, without waiting for clk.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch predictor.
//   btb_entry_t  - one BTB slot {valid, tag, target}; fields sized to
//                  BP_MAX_W so the type can be shared across ADDR_W choices
//                  (ADDR_W must not exceed BP_MAX_W).
//   ctr_init     - weakly-not-taken counter value for a given width.
//   sat_inc/dec  - saturating counter steps.
//   pht_index    - PC-only or gshare (PC ^ history) counter index.
package bp_pkg;

    localparam int BP_MAX_W = 16;

    typedef struct packed {
        logic                valid;
        logic [BP_MAX_W-1:0] tag;
        logic [BP_MAX_W-1:0] target;
    } btb_entry_t;

    function automatic int ctr_init(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

    function automatic int sat_inc(input int v, input int cnt_w);
        return (v >= (1 << cnt_w) - 1) ? v : v + 1;
    endfunction

    function automatic int sat_dec(input int v);
        return (v <= 0) ? 0 : v - 1;
    endfunction

    // History is zero-extended into the low index bits before the XOR.
    function automatic int pht_index(input int pc, input int ghr, input bit gshare,
                                     input int idx_w);
        if (gshare)
            return (pc ^ ghr) & ((1 << idx_w) - 1);
        return pc & ((1 << idx_w) - 1);
    endfunction

endpackage

// File: rtl/bp_pht.sv
// bp_pht: pattern history table of saturating direction counters.
//   clk, rst_n   - clock, async active-low reset (counters -> init value)
//   clr_i        - synchronous flush to init value, beats any write
//   rd_idx_i     - combinational read index; rd_taken_o = counter MSB
//   wr_en_i, wr_idx_i, wr_taken_i - saturating inc (taken) / dec (not taken)
module bp_pht import bp_pkg::*; #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    localparam logic [CNT_W-1:0] INIT = CNT_W'(ctr_init(CNT_W));

    logic [CNT_W-1:0] ctr_q [ENTRIES];
    logic [CNT_W-1:0] ctr_d;

    assign rd_taken_o = ctr_q[rd_idx_i][CNT_W-1];

    always_comb begin
        ctr_d = ctr_q[wr_idx_i];
        if (wr_taken_i)
            ctr_d = CNT_W'(sat_inc(int'(ctr_q[wr_idx_i]), CNT_W));
        else
            ctr_d = CNT_W'(sat_dec(int'(ctr_q[wr_idx_i])));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT;
        end else if (clr_i) begin
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT;
        end else if (wr_en_i) begin
            ctr_q[wr_idx_i] <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direction counters + tagged BTB + global history.
//   lookup_pc      -> pred_taken/pred_hit/pred_target/pred_ghr (0-cycle,
//                     read from registered state, no update bypass)
//   upd_*          - resolved branch from execute; one accepted per cycle
//   clr            - synchronous flush, drops a same-cycle update
//   miss_count     - saturating count of qualified mispredicts
module branch_predictor_btb import bp_pkg::*; #(
    parameter int ADDR_W  = 10,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 4,
    parameter int GSHARE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic              pred_hit,
    output logic [ADDR_W-1:0] pred_target,
    output logic [GHR_W-1:0]  pred_ghr,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_mispredict,
    input  logic              clr,
    output logic [15:0]       miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    btb_entry_t       btb_q [ENTRIES];
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [15:0]      miss_q, miss_d;

    logic [IDX_W-1:0] lk_idx, lk_pht_idx, up_idx, up_pht_idx;
    btb_entry_t       lk_ent;
    logic             pht_taken;
    logic             unused_tgt_hi;

    assign lk_idx     = lookup_pc[IDX_W-1:0];
    assign up_idx     = upd_pc[IDX_W-1:0];
    // Lookups hash with the live history; updates with the snapshot that
    // travelled down the pipe, so both land on the same counter.
    assign lk_pht_idx = IDX_W'(pht_index(int'(lookup_pc), int'(ghr_q), GSHARE != 0, IDX_W));
    assign up_pht_idx = IDX_W'(pht_index(int'(upd_pc), int'(upd_ghr), GSHARE != 0, IDX_W));

    assign lk_ent        = btb_q[lk_idx];
    assign unused_tgt_hi = ^lk_ent.target;

    assign pred_hit    = lk_ent.valid && (lk_ent.tag == BP_MAX_W'(lookup_pc >> IDX_W));
    assign pred_target = pred_hit ? lk_ent.target[ADDR_W-1:0] : '0;
    assign pred_taken  = pred_hit & pht_taken;
    assign pred_ghr    = ghr_q;
    assign miss_count  = miss_q;

    bp_pht #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_pht (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .rd_idx_i   (lk_pht_idx),
        .rd_taken_o (pht_taken),
        .wr_en_i    (upd_valid),
        .wr_idx_i   (up_pht_idx),
        .wr_taken_i (upd_taken)
    );

    always_comb begin
        ghr_d  = ghr_q;
        miss_d = miss_q;
        if (upd_valid) begin
            // Truncating the concatenation drops the oldest bit; also covers GHR_W = 1.
            ghr_d = GHR_W'({ghr_q, upd_taken});
            if (upd_mispredict && miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q  <= '0;
            miss_q <= '0;
        end else if (clr) begin
            ghr_q  <= '0;
            miss_q <= '0;
        end else begin
            ghr_q  <= ghr_d;
            miss_q <= miss_d;
        end
    end

    // Only taken branches allocate; a conflicting tag is simply replaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
        end else if (upd_valid && upd_taken) begin
            btb_q[up_idx] <= '{valid:  1'b1,
                               tag:    BP_MAX_W'(upd_pc >> IDX_W),
                               target: BP_MAX_W'(upd_target)};
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench: two predictors (GSHARE = 0 and 1) share one stimulus stream and
// are compared every negedge against an array-based model, plus literal
// expectations from hand-worked scenarios.
module tb_branch_predictor_btb;

    localparam int ADDR_W = 10, ENTRIES = 16, CNT_W = 2, GHR_W = 4;

    logic clk = 0, rst_n = 0, clr = 0;
    logic [ADDR_W-1:0] lookup_pc = '0, upd_pc = '0, upd_target = '0;
    logic upd_valid = 0, upd_taken = 0, upd_mispredict = 0;
    logic [GHR_W-1:0] upd_ghr = '0;

    logic [1:0] hit_o, tk_o;
    logic [1:0][ADDR_W-1:0] tgt_o;
    logic [1:0][GHR_W-1:0]  ghr_o;
    logic [1:0][15:0]       miss_o;

    int checks = 0, failures = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        branch_predictor_btb #(.ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W),
                               .GHR_W(GHR_W), .GSHARE(g)) u_dut (
            .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc),
            .pred_taken(tk_o[g]), .pred_hit(hit_o[g]), .pred_target(tgt_o[g]),
            .pred_ghr(ghr_o[g]), .upd_valid(upd_valid), .upd_pc(upd_pc),
            .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr),
            .upd_mispredict(upd_mispredict), .clr(clr), .miss_count(miss_o[g]));
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_valid [ENTRIES], m_tag [ENTRIES], m_tgt [ENTRIES];
    int m_ctr [2][ENTRIES];
    int m_ghr, m_miss;

    always @(posedge clk or negedge rst_n) begin : model
        int pc, hidx;
        if (!rst_n || clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
                m_ctr[0][i] = (1 << (CNT_W - 1)) - 1;
                m_ctr[1][i] = (1 << (CNT_W - 1)) - 1;
            end
            m_ghr = 0; m_miss = 0;
        end else if (upd_valid) begin
            pc = int'(upd_pc);
            for (int g = 0; g < 2; g++) begin
                hidx = (g == 1) ? ((pc ^ int'(upd_ghr)) % ENTRIES) : (pc % ENTRIES);
                if (upd_taken) begin
                    if (m_ctr[g][hidx] < (1 << CNT_W) - 1) m_ctr[g][hidx]++;
                end else begin
                    if (m_ctr[g][hidx] > 0) m_ctr[g][hidx]--;
                end
            end
            if (upd_taken) begin
                m_valid[pc % ENTRIES] = 1;
                m_tag[pc % ENTRIES]   = pc / ENTRIES;
                m_tgt[pc % ENTRIES]   = int'(upd_target);
            end
            m_ghr = (m_ghr * 2 + int'(upd_taken)) % (1 << GHR_W);
            if (upd_mispredict && m_miss < 65535) m_miss++;
        end
    end

    always @(negedge clk) begin : compare
        int pc, idx, hidx, ehit, etk, etgt;
        if (rst_n && chk_en) begin
            pc   = int'(lookup_pc);
            idx  = pc % ENTRIES;
            ehit = (m_valid[idx] == 1 && m_tag[idx] == pc / ENTRIES) ? 1 : 0;
            etgt = ehit ? m_tgt[idx] : 0;
            for (int g = 0; g < 2; g++) begin
                hidx = (g == 1) ? ((pc ^ m_ghr) % ENTRIES) : idx;
                etk  = (ehit == 1 && m_ctr[g][hidx] >= (1 << (CNT_W - 1))) ? 1 : 0;
                chk($sformatf("dut%0d.pred_hit", g),    int'(hit_o[g]),  ehit);
                chk($sformatf("dut%0d.pred_taken", g),  int'(tk_o[g]),   etk);
                chk($sformatf("dut%0d.pred_target", g), int'(tgt_o[g]),  etgt);
                chk($sformatf("dut%0d.pred_ghr", g),    int'(ghr_o[g]),  m_ghr);
                chk($sformatf("dut%0d.miss_count", g),  int'(miss_o[g]), m_miss);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_upd(input logic [ADDR_W-1:0] pc, input bit tk,
                          input logic [ADDR_W-1:0] tg, input bit mp);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_target = tg;
        upd_ghr = '0; upd_mispredict = mp;
        tick;
        upd_valid = 0; upd_mispredict = 0;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        chk_en = 1;

        // reset state
        lookup_pc = 10'h05A; #1;
        chk("rst.hit", int'(hit_o[0]), 0);
        chk("rst.taken", int'(tk_o[0]), 0);
        chk("rst.target", int'(tgt_o[0]), 0);
        chk("rst.ghr", int'(ghr_o[0]), 0);
        chk("rst.miss", int'(miss_o[0]), 0);

        // first allocation; same-cycle lookup sees old state
        lookup_pc = 10'h023;
        upd_valid = 1; upd_pc = 10'h023; upd_taken = 1; upd_target = 10'h140;
        #1 chk("alloc.same_cycle_hit", int'(hit_o[0]), 0);
        tick; upd_valid = 0; #1;
        chk("alloc.hit", int'(hit_o[0]), 1);
        chk("alloc.target", int'(tgt_o[0]), 'h140);
        chk("alloc.taken", int'(tk_o[0]), 1);

        // saturate at 3, then walk down
        do_upd(10'h023, 1, 10'h140, 0);
        do_upd(10'h023, 1, 10'h140, 0);
        do_upd(10'h023, 0, 10'h000, 0);
        chk("sat.nt1_taken", int'(tk_o[0]), 1);
        do_upd(10'h023, 0, 10'h000, 0);
        chk("sat.nt2_taken", int'(tk_o[0]), 0);
        chk("sat.nt2_hit", int'(hit_o[0]), 1);

        // tag conflict and eviction
        lookup_pc = 10'h033; #1;
        chk("alias.hit", int'(hit_o[0]), 0);
        chk("alias.taken", int'(tk_o[0]), 0);
        do_upd(10'h033, 1, 10'h200, 0);
        chk("evict.new_hit", int'(hit_o[0]), 1);
        chk("evict.new_target", int'(tgt_o[0]), 'h200);
        lookup_pc = 10'h023; #1;
        chk("evict.old_hit", int'(hit_o[0]), 0);

        // same-cycle update/lookup, no bypass
        upd_valid = 1; upd_pc = 10'h023; upd_taken = 1; upd_target = 10'h155;
        #1 chk("nobypass.pre_hit", int'(hit_o[0]), 0);
        tick; upd_valid = 0; #1;
        chk("nobypass.post_hit", int'(hit_o[0]), 1);
        chk("nobypass.post_target", int'(tgt_o[0]), 'h155);

        // history T,N,T,T
        do_upd(10'h3F0, 1, 10'h001, 0);
        do_upd(10'h3F1, 0, 10'h002, 0);
        do_upd(10'h3F2, 1, 10'h003, 0);
        do_upd(10'h3F3, 1, 10'h004, 0);
        chk("ghr.gshare0", int'(ghr_o[0]), 'b1011);
        chk("ghr.gshare1", int'(ghr_o[1]), 'b1011);

        // random traffic over a small PC window for frequent hits/aliases
        for (int i = 0; i < 3000; i++) begin
            lookup_pc      = ADDR_W'($urandom_range(0, 63));
            upd_valid      = ($urandom_range(0, 3) != 0);
            upd_pc         = ADDR_W'($urandom_range(0, 63));
            upd_taken      = $urandom_range(0, 1) == 1;
            upd_target     = ADDR_W'($urandom);
            upd_ghr        = GHR_W'($urandom);
            upd_mispredict = $urandom_range(0, 1) == 1;
            clr            = ($urandom_range(0, 199) == 0);
            tick;
        end
        clr = 0; upd_valid = 0; upd_mispredict = 0; #1;

        // miss counter saturation
        chk_en = 0;
        upd_valid = 1; upd_mispredict = 1; upd_taken = 0; upd_pc = '0; upd_ghr = '0;
        repeat (70000) @(posedge clk);
        #1 upd_valid = 0; upd_mispredict = 0; #1;
        chk("miss.sat0", int'(miss_o[0]), 'hFFFF);
        chk("miss.sat1", int'(miss_o[1]), 'hFFFF);
        chk_en = 1;

        // clr beats a same-cycle update
        do_upd(10'h123, 1, 10'h0AA, 0);
        lookup_pc = 10'h123; #1;
        chk("preclr.hit", int'(hit_o[0]), 1);
        clr = 1; upd_valid = 1; upd_pc = 10'h2C4; upd_taken = 1;
        upd_target = 10'h3FF; upd_mispredict = 1;
        tick; clr = 0; upd_valid = 0; upd_mispredict = 0; #1;
        chk("clr.miss", int'(miss_o[0]), 0);
        chk("clr.ghr", int'(ghr_o[0]), 0);
        chk("clr.old_hit", int'(hit_o[0]), 0);
        lookup_pc = 10'h2C4; #1;
        chk("clr.dropped_hit", int'(hit_o[0]), 0);

        // asynchronous reset mid-cycle with an update in flight
        do_upd(10'h123, 1, 10'h0AA, 1);
        lookup_pc = 10'h123; #1;
        chk("prerst.hit", int'(hit_o[0]), 1);
        chk("prerst.miss", int'(miss_o[0]), 1);
        upd_valid = 1; upd_pc = 10'h077; upd_taken = 1; upd_target = 10'h011;
        upd_mispredict = 1;
        #1 rst_n = 0;
        #1;
        chk("rst_async.hit", int'(hit_o[0]), 0);
        chk("rst_async.taken", int'(tk_o[0]), 0);
        chk("rst_async.target", int'(tgt_o[0]), 0);
        chk("rst_async.ghr", int'(ghr_o[0]), 0);
        chk("rst_async.miss", int'(miss_o[0]), 0);
        @(posedge clk);
        #3 rst_n = 1; upd_valid = 0; upd_mispredict = 0;
        lookup_pc = 10'h077; #1;
        chk("rst_drop.hit", int'(hit_o[0]), 0);
        tick; #1;
        chk("rst_drop.hit_later", int'(hit_o[0]), 0);
        chk("rst_drop.miss", int'(miss_o[0]), 0);

        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
